// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcodes, FSM state and access-size types for the MIPS pipeline.
// Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    typedef enum logic [0:0] {IDLE, WAIT} lsu_state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

endpackage
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Selects the addressed byte/half lane of read data and extends it.
// Revision    : 1.0
// ============================================================================
module load_ext
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  size_e       size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;

    assign w_byte_sh = rdata >> {addr, 3'b000};
    assign w_half_sh = rdata >> {addr[1], 4'b0000};

    always_comb begin
        data = rdata;
        case (size)
            SZ_B:    data = {{24{sign & w_byte_sh[7]}}, w_byte_sh[7:0]};
            SZ_H:    data = {{16{sign & w_half_sh[15]}}, w_half_sh[15:0]};
            default: data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : M-stage load/store unit: req/ack memory handshake, timeout, M/W latch.
// Revision    : 1.0
// ============================================================================
module mem_stage_lsu
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_PC_M,
    input  logic [31:0] instr_M,
    input  logic [31:0] v_ALUout_M,
    input  logic [31:0] v_R2_M,
    input  logic [4:0]  a_WB_M,
    input  logic [31:0] v_WB_M,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall_M,
    output logic [31:0] a_PC_W,
    output logic [31:0] instr_W,
    output logic [4:0]  a_WB_W,
    output logic [31:0] v_WB_W,
    output logic        misalign_W,
    output logic        buserr_W
);

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    lsu_state_e  r_state, w_state_n;
    logic [7:0]  r_cnt, w_cnt_n;

    logic        w_is_load, w_is_store, w_signed, w_aligned;
    logic        w_misalign, w_go, w_done, w_abort;
    size_e       w_size;
    logic [3:0]  w_lanes;
    logic [31:0] w_ext;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = SZ_W;
        case (instr_M[31:26])
            OP_LW:  begin w_is_load = 1'b1; w_size = SZ_W; end
            OP_LH:  begin w_is_load = 1'b1; w_size = SZ_H; w_signed = 1'b1; end
            OP_LHU: begin w_is_load = 1'b1; w_size = SZ_H; end
            OP_LB:  begin w_is_load = 1'b1; w_size = SZ_B; w_signed = 1'b1; end
            OP_LBU: begin w_is_load = 1'b1; w_size = SZ_B; end
            OP_SW:  begin w_is_store = 1'b1; w_size = SZ_W; end
            OP_SH:  begin w_is_store = 1'b1; w_size = SZ_H; end
            OP_SB:  begin w_is_store = 1'b1; w_size = SZ_B; end
            default: ;
        endcase
    end

    always_comb begin
        w_aligned = 1'b1;
        w_lanes   = 4'b1111;
        case (w_size)
            SZ_W: begin
                w_aligned = (v_ALUout_M[1:0] == 2'b00);
                w_lanes   = 4'b1111;
            end
            SZ_H: begin
                w_aligned = ~v_ALUout_M[0];
                w_lanes   = v_ALUout_M[1] ? 4'b1100 : 4'b0011;
            end
            default: w_lanes = 4'b0001 << v_ALUout_M[1:0];
        endcase
    end

    assign w_misalign = (w_is_load | w_is_store) & ~w_aligned;
    assign w_go       = (w_is_load | w_is_store) & w_aligned;

    assign m_addr   = {v_ALUout_M[31:2], 2'b00};
    assign m_we     = m_req & w_is_store;
    assign m_byteen = (w_go & w_is_store) ? w_lanes : 4'b0000;

    always_comb begin
        m_wdata = v_R2_M;
        case (w_size)
            SZ_H:    m_wdata = {2{v_R2_M[15:0]}};
            SZ_B:    m_wdata = {4{v_R2_M[7:0]}};
            default: m_wdata = v_R2_M;
        endcase
    end

    load_ext u_load_ext (
        .rdata (m_rdata),
        .addr  (v_ALUout_M[1:0]),
        .size  (w_size),
        .sign  (w_signed),
        .data  (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Ack takes priority over the timeout when both land in the same cycle.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        m_req     = 1'b0;
        stall_M   = 1'b0;
        w_done    = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    m_req = 1'b1;
                    if (m_ack) begin
                        w_done = 1'b1;
                    end else begin
                        stall_M   = 1'b1;
                        w_state_n = WAIT;
                        w_cnt_n   = 8'd1;
                    end
                end
            end
            WAIT: begin
                m_req = 1'b1;
                if (m_ack) begin
                    w_done    = 1'b1;
                    w_state_n = IDLE;
                    w_cnt_n   = 8'd0;
                end else if (r_cnt == c_MAX_WAIT) begin
                    w_abort   = 1'b1;
                    w_state_n = IDLE;
                    w_cnt_n   = 8'd0;
                end else begin
                    stall_M = 1'b1;
                    w_cnt_n = r_cnt + 8'd1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || stall_M) begin
            a_PC_W     <= 32'd0;
            instr_W    <= 32'd0;
            a_WB_W     <= 5'd0;
            v_WB_W     <= 32'd0;
            misalign_W <= 1'b0;
            buserr_W   <= 1'b0;
        end else begin
            a_PC_W     <= a_PC_M;
            instr_W    <= instr_M;
            a_WB_W     <= (w_is_store | w_misalign | w_abort) ? 5'd0 : a_WB_M;
            v_WB_W     <= (w_done & w_is_load) ? w_ext : v_WB_M;
            misalign_W <= w_misalign;
            buserr_W   <= w_abort;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Scoreboard bench for mem_stage_lsu with directed load/store vectors.
// Revision    : 1.0
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_PC_M, instr_M, v_ALUout_M, v_R2_M, v_WB_M, m_rdata;
    logic [4:0]  a_WB_M;
    logic        m_ack;
    logic        m_req, m_we, stall_M, misalign_W, buserr_W;
    logic [31:0] m_addr, m_wdata, a_PC_W, instr_W, v_WB_W;
    logic [3:0]  m_byteen;
    logic [4:0]  a_WB_W;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  awb;
        logic [31:0] v;
        logic        chk_v;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb_q[$];

    mem_stage_lsu #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_PC_M     (a_PC_M),
        .instr_M    (instr_M),
        .v_ALUout_M (v_ALUout_M),
        .v_R2_M     (v_R2_M),
        .a_WB_M     (a_WB_M),
        .v_WB_M     (v_WB_M),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_byteen   (m_byteen),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack),
        .stall_M    (stall_M),
        .a_PC_W     (a_PC_W),
        .instr_W    (instr_W),
        .a_WB_W     (a_WB_W),
        .v_WB_W     (v_WB_W),
        .misalign_W (misalign_W),
        .buserr_W   (buserr_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_PC_M = 0; instr_M = 0; v_ALUout_M = 0; v_R2_M = 0;
        a_WB_M = 0; v_WB_M = 0; m_rdata = 0; m_ack = 0;
    endtask

    // Monitor: every non-bubble W record is popped from the scoreboard and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && a_PC_W != 32'd0) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL w_record: unexpected pc=%h instr=%h", a_PC_W, instr_W);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (a_PC_W !== e.pc || instr_W !== e.instr || a_WB_W !== e.awb ||
                        misalign_W !== e.mis || buserr_W !== e.berr ||
                        (e.chk_v && v_WB_W !== e.v)) begin
                        n_errors++;
                        $display("FAIL w_record: got pc=%h ins=%h awb=%0d v=%h mis=%b berr=%b expected pc=%h ins=%h awb=%0d v=%h mis=%b berr=%b",
                                 a_PC_W, instr_W, a_WB_W, v_WB_W, misalign_W, buserr_W,
                                 e.pc, e.instr, e.awb, e.v, e.mis, e.berr);
                    end
                end
            end
        end
    end

    // Presents one M-stage op starting just after a posedge; ack_after<0 means never ack.
    task automatic run_op(input string name, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] addr, input logic [31:0] r2, input logic [4:0] awb,
                          input logic [31:0] wbv, input logic [31:0] rdata, input int ack_after,
                          input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input int exp_stall, input exp_t e);
        int  stalls;
        logic done;
        logic was_stall;
        stalls = 0;
        done = 1'b0;
        was_stall = 1'b0;
        a_PC_M = pc; instr_M = instr; v_ALUout_M = addr; v_R2_M = r2;
        a_WB_M = awb; v_WB_M = wbv; m_rdata = rdata;
        sb_q.push_back(e);
        for (int c = 0; c < 100; c++) begin
            m_ack = (c == ack_after);
            if (was_stall)
                check({name, "_bubble"}, a_PC_W | instr_W | v_WB_W | {27'd0, a_WB_W}, 32'd0);
            #2;
            if (c == 0) begin
                check({name, "_req"}, {31'd0, m_req}, {31'd0, exp_req});
                check({name, "_byteen"}, {28'd0, m_byteen}, {28'd0, exp_be});
                if (exp_be != 4'd0) begin
                    check({name, "_wdata"}, m_wdata, exp_wd);
                    check({name, "_we"}, {31'd0, m_we}, 32'd1);
                end
            end
            if (stall_M) stalls++;
            was_stall = stall_M;
            done = !stall_M;
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) begin
            n_errors++;
            $display("FAIL %s_timeout: stall never released", name);
        end
        check({name, "_stall_cycles"}, stalls, exp_stall);
        idle_inputs();
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] awb,
                                input logic [31:0] v, input logic chk_v, input logic mis, input logic berr);
        exp_t e;
        e.pc = pc; e.instr = instr; e.awb = awb; e.v = v; e.chk_v = chk_v; e.mis = mis; e.berr = berr;
        return e;
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_w_out", a_PC_W | instr_W | v_WB_W | {27'd0, a_WB_W}, 32'd0);
        check("rst_flags", {30'd0, misalign_W, buserr_W}, 32'd0);
        check("rst_req_stall", {30'd0, m_req, stall_M}, 32'd0);

        run_op("lw", 32'h1000, 32'h8C08_0000, 32'h100, 32'h0, 5'd8, 32'h0, 32'hDEADBEEF, 0,
               1'b1, 4'b0000, 32'h0, 0, mk(32'h1000, 32'h8C08_0000, 5'd8, 32'hDEADBEEF, 1, 0, 0));
        run_op("sb", 32'h1004, 32'hA000_0000, 32'h103, 32'h12345678, 5'd5, 32'h55, 32'h0, 3,
               1'b1, 4'b1000, 32'h78787878, 3, mk(32'h1004, 32'hA000_0000, 5'd0, 32'h55, 1, 0, 0));
        run_op("lh", 32'h1008, 32'h8400_0000, 32'h102, 32'h0, 5'd3, 32'h0, 32'h8001FFFF, 0,
               1'b1, 4'b0000, 32'h0, 0, mk(32'h1008, 32'h8400_0000, 5'd3, 32'hFFFF8001, 1, 0, 0));
        run_op("lhu", 32'h100C, 32'h9400_0000, 32'h102, 32'h0, 5'd4, 32'h0, 32'h8001FFFF, 0,
               1'b1, 4'b0000, 32'h0, 0, mk(32'h100C, 32'h9400_0000, 5'd4, 32'h00008001, 1, 0, 0));
        run_op("lw_mis", 32'h1010, 32'h8C00_0000, 32'h101, 32'h0, 5'd6, 32'h0, 32'h0, 0,
               1'b0, 4'b0000, 32'h0, 0, mk(32'h1010, 32'h8C00_0000, 5'd0, 32'h0, 0, 1, 0));
        run_op("lb", 32'h1014, 32'h8000_0000, 32'h101, 32'h0, 5'd7, 32'h0, 32'h0000_8000, 0,
               1'b1, 4'b0000, 32'h0, 0, mk(32'h1014, 32'h8000_0000, 5'd7, 32'hFFFFFF80, 1, 0, 0));
        run_op("lbu", 32'h1018, 32'h9000_0000, 32'h101, 32'h0, 5'd7, 32'h0, 32'h0000_8000, 0,
               1'b1, 4'b0000, 32'h0, 0, mk(32'h1018, 32'h9000_0000, 5'd7, 32'h00000080, 1, 0, 0));
        run_op("sh", 32'h101C, 32'hA400_0000, 32'h102, 32'hAAAABEEF, 5'd2, 32'h66, 32'h0, 1,
               1'b1, 4'b1100, 32'hBEEFBEEF, 1, mk(32'h101C, 32'hA400_0000, 5'd0, 32'h66, 1, 0, 0));
        run_op("sw", 32'h1020, 32'hAC00_0000, 32'h200, 32'hCAFEF00D, 5'd2, 32'h11, 32'h0, 0,
               1'b1, 4'b1111, 32'hCAFEF00D, 0, mk(32'h1020, 32'hAC00_0000, 5'd0, 32'h11, 1, 0, 0));
        run_op("timeout", 32'h1024, 32'h8C00_0000, 32'h300, 32'h0, 5'd9, 32'h0, 32'h0, -1,
               1'b1, 4'b0000, 32'h0, 4, mk(32'h1024, 32'h8C00_0000, 5'd0, 32'h0, 0, 0, 1));
        // Ack arriving after the abort, alongside a non-memory op, must be ignored.
        run_op("late_ack", 32'h1100, 32'h0022_1820, 32'h0, 32'h0, 5'd9, 32'h77, 32'h0, 0,
               1'b0, 4'b0000, 32'h0, 0, mk(32'h1100, 32'h0022_1820, 5'd9, 32'h77, 1, 0, 0));

        // Reset two cycles into WAIT abandons the transaction.
        a_PC_M = 32'h1200; instr_M = 32'h8C00_0000; v_ALUout_M = 32'h400; a_WB_M = 5'd10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_stall", {31'd0, stall_M}, 32'd1);
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        check("wrst_req_stall", {30'd0, m_req, stall_M}, 32'd0);
        check("wrst_w_out", a_PC_W | instr_W | v_WB_W | {27'd0, a_WB_W}, 32'd0);
        check("wrst_flags", {30'd0, misalign_W, buserr_W}, 32'd0);
        m_ack = 1'b1;
        #2;
        check("wrst_late_ack", {30'd0, m_req, stall_M}, 32'd0);
        @(posedge clk); #1;
        m_ack = 1'b0;
        check("wrst_after_ack", a_PC_W | {27'd0, a_WB_W} | {30'd0, misalign_W, buserr_W}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
